// File: rtl/stage_classifier_seq.sv
// ---------------------------------------------------------------------------
// stage_classifier_seq
//
// Evaluates one cascade stage of a Haar-style classifier over an integral
// image window. The block runs through the stage's weak classifiers one at a
// time:
//   - it fetches the classifier's 18 parameter bytes from ROM,
//   - reads the twelve integral-image corners named by those bytes,
//   - forms the weighted feature from three rectangle sums,
//   - adds the left or right vote to a saturating stage accumulator.
// After the last classifier it reads the stage threshold byte. The verdict is
// accumulator >= threshold.
//
// Ports
//   clk_fpga          : sole clock, rising edge
//   reset             : synchronous, active-high
//   i_start           : one-cycle start request, honoured only when idle
//   i_num_classifiers : classifier count for the stage (captured at start)
//   i_rom_base        : ROM byte address of the first classifier (captured)
//   o_rom_addr        : ROM read address, data returns one cycle later
//   i_rom_data        : ROM read data
//   o_ii_addr         : integral-image read address, data one cycle later
//   i_ii_data         : unsigned integral-image word
//   o_busy            : high from start acceptance through the o_done cycle
//   o_done            : one-cycle result-valid pulse
//   o_iscandidate     : stage verdict, held until the next accepted start
// ---------------------------------------------------------------------------
module stage_classifier_seq #(
    parameter int DATA_WIDTH_8             = 8,
    parameter int II_WIDTH                 = 16,
    parameter int INTEGRAL_WIDTH           = 24,
    parameter int INTEGRAL_HEIGHT          = 10,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18,
    parameter int MAX_CLASSIFIERS          = 255,
    parameter int ACC_WIDTH                = 16
) (
    input  logic                    clk_fpga,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [7:0]              i_num_classifiers,
    input  logic [15:0]             i_rom_base,
    output logic [15:0]             o_rom_addr,
    input  logic [DATA_WIDTH_8-1:0] i_rom_data,
    output logic [7:0]              o_ii_addr,
    input  logic [II_WIDTH-1:0]     i_ii_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_iscandidate
);

    localparam int NP     = NUM_PARAM_PER_CLASSIFIER;
    localparam int IDX_W  = $clog2(NP);
    localparam int STEP_W = 5;
    localparam int RECT_W = II_WIDTH + 2;
    localparam int PROD_W = RECT_W + DATA_WIDTH_8;
    localparam int FEAT_W = PROD_W + 2;
    localparam int WINDOW = INTEGRAL_WIDTH * INTEGRAL_HEIGHT;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        PARAM,
        RECT,
        EVAL,
        THRESH,
        DONE
    } state_t;

    state_t                          state_q, state_d;
    logic [STEP_W-1:0]               step_q, step_d;
    logic [7:0]                      cls_q, cls_d;
    logic [7:0]                      count_q, count_d;
    logic [15:0]                     rom_addr_q, rom_addr_d;
    logic [7:0]                      ii_addr_q, ii_addr_d;
    logic signed [ACC_WIDTH-1:0]     acc_q, acc_d;
    logic [DATA_WIDTH_8-1:0]         stage_thr_q, stage_thr_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            cand_q, cand_d;
    logic [DATA_WIDTH_8-1:0]         param_q [NP];
    logic [DATA_WIDTH_8-1:0]         param_d [NP];
    logic [II_WIDTH-1:0]             rect_q [12];
    logic [II_WIDTH-1:0]             rect_d [12];

    logic signed [FEAT_W-1:0]        feature;
    logic signed [FEAT_W-1:0]        clf_thr;
    logic [DATA_WIDTH_8-1:0]         sel_val;
    logic signed [ACC_WIDTH:0]       acc_sum;
    logic signed [ACC_WIDTH-1:0]     acc_next;
    logic [7:0]                      count_clamped;

    // Rectangle corner r (0..11) lives at byte r + r/4: every fifth byte of
    // the layout is a weight, not a corner index.
    function automatic logic [IDX_W-1:0] rect_byte(input logic [STEP_W-1:0] r);
        return IDX_W'(r + (r >> 2));
    endfunction

    // Keep integral-image reads inside the window even if a ROM byte is bad.
    function automatic logic [7:0] window_index(input logic [DATA_WIDTH_8-1:0] b);
        if (32'(b) >= 32'(WINDOW)) begin
            return 8'(WINDOW - 1);
        end
        return 8'(b);
    endfunction

    // A - B - C + D over unsigned corners; two extra bits cover the range.
    function automatic logic signed [RECT_W-1:0] rect_sum(
        input logic [II_WIDTH-1:0] a,
        input logic [II_WIDTH-1:0] b,
        input logic [II_WIDTH-1:0] c,
        input logic [II_WIDTH-1:0] d
    );
        return $signed({2'b00, a}) - $signed({2'b00, b})
             - $signed({2'b00, c}) + $signed({2'b00, d});
    endfunction

    // Signed weight times rectangle sum, widened so three terms never overflow.
    function automatic logic signed [FEAT_W-1:0] weighted(
        input logic [DATA_WIDTH_8-1:0]  w,
        input logic signed [RECT_W-1:0] s
    );
        logic signed [PROD_W-1:0] wx;
        logic signed [PROD_W-1:0] sx;
        logic signed [PROD_W-1:0] p;
        wx = {{(PROD_W-DATA_WIDTH_8){w[DATA_WIDTH_8-1]}}, w};
        sx = {{DATA_WIDTH_8{s[RECT_W-1]}}, s};
        p  = wx * sx;
        return {{2{p[PROD_W-1]}}, p};
    endfunction

    assign count_clamped = (32'(i_num_classifiers) > 32'(MAX_CLASSIFIERS))
                         ? 8'(MAX_CLASSIFIERS) : i_num_classifiers;

    // Weak-classifier datapath. It is only consumed in EVAL, when every
    // parameter byte and corner value for the current classifier is captured.
    // The vote is added with one guard bit. A disagreement between the top
    // two bits of the sum means it left the accumulator range, so it pins to
    // the matching rail instead of wrapping.
    always_comb begin
        feature = weighted(param_q[4],
                           rect_sum(rect_q[0], rect_q[1], rect_q[2], rect_q[3]))
                + weighted(param_q[9],
                           rect_sum(rect_q[4], rect_q[5], rect_q[6], rect_q[7]))
                + weighted(param_q[14],
                           rect_sum(rect_q[8], rect_q[9], rect_q[10], rect_q[11]));
        clf_thr = {{(FEAT_W-DATA_WIDTH_8){param_q[15][DATA_WIDTH_8-1]}}, param_q[15]};
        sel_val = (feature < clf_thr) ? param_q[16] : param_q[17];
        acc_sum = $signed({acc_q[ACC_WIDTH-1], acc_q})
                + $signed({{(ACC_WIDTH+1-DATA_WIDTH_8){sel_val[DATA_WIDTH_8-1]}}, sel_val});
        if (acc_sum[ACC_WIDTH] != acc_sum[ACC_WIDTH-1]) begin
            acc_next = acc_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_next = acc_sum[ACC_WIDTH-1:0];
        end
    end

    // Sequencer next-state logic.
    //
    // step_q counts cycles inside a state. In PARAM, step j shows address j
    // and captures the byte requested one cycle earlier. Step 18 therefore
    // only captures. RECT works the same way over the twelve corners.
    //
    // rom_addr is never reloaded from base after start. It walks forward one
    // byte at a time, so the increment after EVAL lands on the next
    // classifier or on the stage-threshold byte.
    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cls_d       = cls_q;
        count_d     = count_q;
        rom_addr_d  = rom_addr_q;
        ii_addr_d   = ii_addr_q;
        acc_d       = acc_q;
        stage_thr_d = stage_thr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cand_d      = cand_q;
        param_d     = param_q;
        rect_d      = rect_q;

        case (state_q)
            IDLE: begin
                // busy_q is still high here only during the o_done cycle.
                if (busy_q) begin
                    busy_d = 1'b0;
                end else if (i_start) begin
                    busy_d     = 1'b1;
                    acc_d      = '0;
                    cand_d     = 1'b0;
                    count_d    = count_clamped;
                    cls_d      = '0;
                    step_d     = '0;
                    rom_addr_d = i_rom_base;
                    state_d    = (count_clamped == 8'd0) ? THRESH : PARAM;
                end
            end

            PARAM: begin
                if (step_q != '0) begin
                    param_d[IDX_W'(step_q - 1'b1)] = i_rom_data;
                end
                if (step_q < STEP_W'(NP - 1)) begin
                    rom_addr_d = rom_addr_q + 16'd1;
                end
                if (step_q == STEP_W'(NP)) begin
                    step_d    = '0;
                    ii_addr_d = window_index(param_q[0]);
                    state_d   = RECT;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            RECT: begin
                if (step_q != '0) begin
                    rect_d[4'(step_q - 1'b1)] = i_ii_data;
                end
                if (step_q < STEP_W'(11)) begin
                    ii_addr_d = window_index(param_q[rect_byte(step_q + 1'b1)]);
                end
                if (step_q == STEP_W'(12)) begin
                    step_d  = '0;
                    state_d = EVAL;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end

            EVAL: begin
                acc_d      = acc_next;
                rom_addr_d = rom_addr_q + 16'd1;
                step_d     = '0;
                if (({1'b0, cls_q} + 9'd1) < {1'b0, count_q}) begin
                    cls_d   = cls_q + 8'd1;
                    state_d = PARAM;
                end else begin
                    state_d = THRESH;
                end
            end

            THRESH: begin
                if (step_q == '0) begin
                    step_d = step_q + 1'b1;
                end else begin
                    stage_thr_d = i_rom_data;
                    step_d      = '0;
                    state_d     = DONE;
                end
            end

            DONE: begin
                cand_d  = (acc_q >= $signed({{(ACC_WIDTH-DATA_WIDTH_8){stage_thr_q[DATA_WIDTH_8-1]}},
                                             stage_thr_q}));
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and result registers.
    // Reset returns to IDLE with all outputs low. A stage that is in flight
    // is abandoned without a done pulse.
    always_ff @(posedge clk_fpga) begin
        if (reset) begin
            state_q     <= IDLE;
            step_q      <= '0;
            cls_q       <= '0;
            count_q     <= '0;
            rom_addr_q  <= '0;
            ii_addr_q   <= '0;
            acc_q       <= '0;
            stage_thr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cand_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cls_q       <= cls_d;
            count_q     <= count_d;
            rom_addr_q  <= rom_addr_d;
            ii_addr_q   <= ii_addr_d;
            acc_q       <= acc_d;
            stage_thr_q <= stage_thr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cand_q      <= cand_d;
        end
    end

    // Parameter and corner capture buffers. They are always overwritten
    // before use within a classifier, so they need no reset.
    always_ff @(posedge clk_fpga) begin
        param_q <= param_d;
        rect_q  <= rect_d;
    end

    assign o_rom_addr    = rom_addr_q;
    assign o_ii_addr     = ii_addr_q;
    assign o_busy        = busy_q;
    assign o_done        = done_q;
    assign o_iscandidate = cand_q;

endmodule

// File: tb/tb_stage_classifier_seq.sv
// ---------------------------------------------------------------------------
// tb_stage_classifier_seq
//
// Scoreboard bench for stage_classifier_seq.
//   - A stimulus thread loads ROM and integral-image memories, computes the
//     expected verdict and latency from the classifier rules, and queues it.
//   - A monitor pops an entry on every o_done and compares it.
//   - A second instance with ACC_WIDTH=8 covers accumulator saturation.
// ---------------------------------------------------------------------------
module tb_stage_classifier_seq;

    typedef struct {
        string name;
        bit    cand;
        int    startCyc;
        int    latency;
    } exp_t;

    logic        clk_fpga = 1'b0;
    logic        reset;
    logic        i_start, i_start_s;
    logic [7:0]  i_num_classifiers, i_num_s;
    logic [15:0] i_rom_base, i_base_s;
    logic [15:0] o_rom_addr, o_rom_addr_s;
    logic [7:0]  i_rom_data, i_rom_data_s;
    logic [7:0]  o_ii_addr, o_ii_addr_s;
    logic [15:0] i_ii_data, i_ii_data_s;
    logic        o_busy, o_done, o_iscandidate;
    logic        o_busy_s, o_done_s, o_iscandidate_s;

    logic [7:0]  rom [0:65535];
    logic [15:0] iiMem [0:255];

    exp_t        sb [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          prevDone = 1'b0;

    always #5 clk_fpga = ~clk_fpga;

    // Cycle counter used to time o_done against the accepting start edge.
    always @(posedge clk_fpga) cyc <= cyc + 1;

    // Synchronous memories: data for the address shown this cycle appears
    // on the next cycle.
    always @(posedge clk_fpga) begin
        i_rom_data   <= rom[o_rom_addr];
        i_ii_data    <= iiMem[o_ii_addr];
        i_rom_data_s <= rom[o_rom_addr_s];
        i_ii_data_s  <= iiMem[o_ii_addr_s];
    end

    stage_classifier_seq dut (
        .clk_fpga          (clk_fpga),
        .reset             (reset),
        .i_start           (i_start),
        .i_num_classifiers (i_num_classifiers),
        .i_rom_base        (i_rom_base),
        .o_rom_addr        (o_rom_addr),
        .i_rom_data        (i_rom_data),
        .o_ii_addr         (o_ii_addr),
        .i_ii_data         (i_ii_data),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_iscandidate     (o_iscandidate)
    );

    stage_classifier_seq #(.ACC_WIDTH(8)) dut_s (
        .clk_fpga          (clk_fpga),
        .reset             (reset),
        .i_start           (i_start_s),
        .i_num_classifiers (i_num_s),
        .i_rom_base        (i_base_s),
        .o_rom_addr        (o_rom_addr_s),
        .i_rom_data        (i_rom_data_s),
        .o_ii_addr         (o_ii_addr_s),
        .i_ii_data         (i_ii_data_s),
        .o_busy            (o_busy_s),
        .o_done            (o_done_s),
        .o_iscandidate     (o_iscandidate_s)
    );

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int sbyte(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    function automatic logic [7:0] romAt(input int addr);
        logic [15:0] a;
        a = 16'(addr);
        return rom[a];
    endfunction

    function automatic int iiAt(input logic [7:0] idx);
        return int'(iiMem[idx]);
    endfunction

    task automatic setByte(input int addr, input int val);
        logic [15:0] a;
        a = 16'(addr);
        rom[a] = 8'(val);
    endtask

    // Reference stage evaluation in plain integer arithmetic.
    function automatic void refStage(input int base, input int n, input int accW,
                                     output bit cand);
        int hi, lo, a, feat, rs, acc;
        hi  = (1 << (accW - 1)) - 1;
        lo  = -(1 << (accW - 1));
        acc = 0;
        for (int k = 0; k < n; k++) begin
            a    = base + 18 * k;
            feat = 0;
            for (int r = 0; r < 3; r++) begin
                rs = iiAt(romAt(a + 5*r)) - iiAt(romAt(a + 5*r + 1))
                   - iiAt(romAt(a + 5*r + 2)) + iiAt(romAt(a + 5*r + 3));
                feat += sbyte(romAt(a + 5*r + 4)) * rs;
            end
            acc += (feat < sbyte(romAt(a + 15))) ? sbyte(romAt(a + 16)) : sbyte(romAt(a + 17));
            if (acc > hi) acc = hi;
            if (acc < lo) acc = lo;
        end
        cand = (acc >= sbyte(romAt(base + 18 * n)));
    endfunction

    task automatic randomClassifier(input int a);
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 4; j++) setByte(a + 5*r + j, int'($urandom_range(0, 239)));
            setByte(a + 5*r + 4, ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 255)));
        end
        setByte(a + 15, int'($urandom_range(0, 255)));
        setByte(a + 16, int'($urandom_range(0, 255)));
        setByte(a + 17, int'($urandom_range(0, 255)));
    endtask

    // Fixed-vote classifier: zero weights give feature 0, threshold 0 picks right.
    task automatic voteClassifier(input int a, input int right);
        for (int j = 0; j < 18; j++) setByte(a + j, 0);
        setByte(a + 16, -1);
        setByte(a + 17, right);
    endtask

    // Issue one start and queue its expectation. Returns in the first stage cycle.
    task automatic applyStimulus(input string name, input logic [15:0] base,
                                 input logic [7:0] n, input bit cand);
        exp_t e;
        @(negedge clk_fpga);
        e.name     = name;
        e.cand     = cand;
        e.startCyc = cyc + 1;
        e.latency  = 33 * int'(n) + 3;
        sb.push_back(e);
        i_rom_base        = base;
        i_num_classifiers = n;
        i_start           = 1'b1;
        @(negedge clk_fpga);
        i_start           = 1'b0;
        i_rom_base        = 16'($urandom);
        i_num_classifiers = 8'($urandom);
    endtask

    task automatic waitIdle(input int bound);
        int k;
        k = 0;
        while (sb.size() != 0 && k < bound) begin
            @(negedge clk_fpga);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout: %0d results pending after %0d cycles", sb.size(), bound);
            sb.delete();
        end
        @(negedge clk_fpga);
    endtask

    task automatic runSat(input string name, input logic [15:0] base,
                          input logic [7:0] n, input bit cand);
        int k;
        @(negedge clk_fpga);
        i_base_s  = base;
        i_num_s   = n;
        i_start_s = 1'b1;
        @(negedge clk_fpga);
        i_start_s = 1'b0;
        k = 0;
        while (!o_done_s && k < 1000) begin
            @(negedge clk_fpga);
            k++;
        end
        if (!o_done_s) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: no o_done after %0d cycles", name, k);
        end else begin
            checkOutput({name, "_cand"}, o_iscandidate_s, cand);
            checkOutput({name, "_latency"}, k, 33 * int'(n) + 3);
        end
    endtask

    // Monitor: every o_done must match the oldest queued expectation. busy
    // must still be high on that cycle and low on the next one.
    always @(negedge clk_fpga) begin
        exp_t e;
        if (!reset) begin
            if (prevDone) checkOutput("busy_after_done", o_busy, 0);
            if (o_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: o_done=1 at cycle %0d, expected none", cyc);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, "_cand"}, o_iscandidate, e.cand);
                    checkOutput({e.name, "_latency"}, cyc - e.startCyc, e.latency);
                    checkOutput({e.name, "_busy"}, o_busy, 1);
                end
            end
            prevDone = o_done;
        end else begin
            prevDone = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  base;
        int  n;
        bit  cand;
        reset = 1'b1;
        i_start = 1'b0; i_num_classifiers = '0; i_rom_base = '0;
        i_start_s = 1'b0; i_num_s = '0; i_base_s = '0;
        for (int i = 0; i < 256; i++) iiMem[i] = '0;
        repeat (3) @(negedge clk_fpga);
        checkOutput("reset_busy", o_busy, 0);
        checkOutput("reset_done", o_done, 0);
        checkOutput("reset_cand", o_iscandidate, 0);
        checkOutput("reset_rom_addr", o_rom_addr, 0);
        checkOutput("reset_ii_addr", o_ii_addr, 0);
        reset = 1'b0;
        @(negedge clk_fpga);

        // Single classifier picks left (-3) against stage threshold 5.
        // A spurious start during PARAM must be ignored.
        base = 16'h0100;
        setByte(base + 0, 1);  setByte(base + 1, 2);  setByte(base + 2, 3);  setByte(base + 3, 4);
        setByte(base + 4, -1);
        setByte(base + 5, 5);  setByte(base + 6, 6);  setByte(base + 7, 7);  setByte(base + 8, 8);
        setByte(base + 9, 2);
        setByte(base + 10, 9); setByte(base + 11, 9); setByte(base + 12, 9); setByte(base + 13, 9);
        setByte(base + 14, 0);
        setByte(base + 15, -50); setByte(base + 16, -3); setByte(base + 17, 7);
        setByte(base + 18, 5);
        iiMem[1] = 16'd100; iiMem[2] = 16'd30; iiMem[3] = 16'd50; iiMem[4] = 16'd20;
        iiMem[5] = 16'd0;   iiMem[6] = 16'd10; iiMem[7] = 16'd0;  iiMem[8] = 16'd0;
        iiMem[9] = 16'd1234;
        applyStimulus("n1_left", 16'(base), 8'd1, 1'b0);
        for (int rel = 0; rel < 31; rel++) begin
            if (rel <= 18) checkOutput($sformatf("rom_addr_rel%0d", rel), o_rom_addr, base + ((rel > 17) ? 17 : rel));
            if (rel >= 19) checkOutput($sformatf("ii_addr_rel%0d", rel), o_ii_addr, (rel - 19 < 8) ? rel - 18 : 9);
            if (rel == 5) begin
                i_start = 1'b1; i_num_classifiers = 8'd7; i_rom_base = 16'h4000;
            end
            if (rel == 6) i_start = 1'b0;
            @(negedge clk_fpga);
        end
        waitIdle(60);

        // Two right votes of 7 reach threshold 14 exactly.
        base = 16'h0200;
        voteClassifier(base, 7);
        voteClassifier(base + 18, 7);
        setByte(base + 36, 14);
        applyStimulus("n2_equal", 16'(base), 8'd2, 1'b1);
        waitIdle(100);

        // Empty stage compares 0 against the threshold byte.
        setByte(16'h0300, 0);
        applyStimulus("n0_thr0", 16'h0300, 8'd0, 1'b1);
        waitIdle(20);
        setByte(16'h0300, 1);
        applyStimulus("n0_thr1", 16'h0300, 8'd0, 1'b0);
        waitIdle(20);

        // 8-bit accumulator: +200 pins at 127 and -200 pins at -128.
        for (int k = 0; k < 20; k++) voteClassifier(16'h0400 + 18 * k, 10);
        setByte(16'h0400 + 360, 127);
        runSat("sat_pos", 16'h0400, 8'd20, 1'b1);
        for (int k = 0; k < 20; k++) voteClassifier(16'h0800 + 18 * k, -10);
        setByte(16'h0800 + 360, -127);
        runSat("sat_neg", 16'h0800, 8'd20, 1'b0);

        // Reset partway through a three-classifier stage, then rerun it.
        base = 16'h1000;
        for (int k = 0; k < 3; k++) randomClassifier(base + 18 * k);
        setByte(base + 54, int'($urandom_range(0, 40)) - 20);
        for (int i = 0; i < 256; i++) iiMem[i] = 16'($urandom);
        refStage(base, 3, 16, cand);
        applyStimulus("aborted", 16'(base), 8'd3, cand);
        repeat (19) @(negedge clk_fpga);
        sb.delete();
        reset = 1'b1;
        @(negedge clk_fpga);
        checkOutput("abort_busy", o_busy, 0);
        checkOutput("abort_done", o_done, 0);
        checkOutput("abort_rom_addr", o_rom_addr, 0);
        reset = 1'b0;
        repeat (110) @(negedge clk_fpga);
        applyStimulus("restart", 16'(base), 8'd3, cand);
        waitIdle(130);

        // Random stages against the reference model.
        for (int t = 0; t < 12; t++) begin
            n    = int'($urandom_range(0, 4));
            base = int'($urandom_range(0, 60000));
            for (int k = 0; k < n; k++) randomClassifier(base + 18 * k);
            setByte(base + 18 * n, int'($urandom_range(0, 60)) - 30);
            for (int i = 0; i < 256; i++) begin
                iiMem[i] = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom);
            end
            refStage(base, n, 16, cand);
            applyStimulus($sformatf("rand%0d", t), 16'(base), 8'(n), cand);
            waitIdle(33 * n + 20);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stage_classifier_seq.md
STAGE_CLASSIFIER_SEQ -- requirements
Module: stage_classifier_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH_8, default 8: width of every ROM byte.
REQ-002 SHALL have parameter II_WIDTH, default 16: width of each integral-image word.
REQ-003 SHALL have parameter INTEGRAL_WIDTH, default 24, and INTEGRAL_HEIGHT, default 10: window size, product ≤ 256.
REQ-004 SHALL have parameter NUM_PARAM_PER_CLASSIFIER, default 18: ROM bytes per classifier.
REQ-005 SHALL have parameter MAX_CLASSIFIERS, default 255, and ACC_WIDTH, default 16: signed stage-accumulator width.
REQ-006 clk_fpga  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 i_start  in  1  one-cycle start request, sampled only in IDLE.
REQ-009 i_num_classifiers  in  8  classifier count for this stage, captured at start.
REQ-010 i_rom_base  in  16  ROM byte address of the first classifier, captured at start.
REQ-011 o_rom_addr  out  16  ROM read address; data returns 1 cycle later.
REQ-012 i_rom_data  in  DATA_WIDTH_8  ROM read data.
REQ-013 o_ii_addr  out  8  integral-image read address; data returns 1 cycle later.
REQ-014 i_ii_data  in  II_WIDTH  unsigned integral-image read data.
REQ-015 o_busy  out  1  high from start acceptance until o_done cycle inclusive.
REQ-016 o_done  out  1  one-cycle pulse: result valid.
REQ-017 o_iscandidate  out  1  stage verdict, held from o_done until next accepted start.

Function
REQ-018 States SHALL be IDLE, PARAM, RECT, EVAL, THRESH, DONE; IDLE→PARAM on i_start (or IDLE→THRESH if i_num_classifiers=0).
REQ-019 PARAM SHALL last 19 cycles: addresses base+18k+0..17 issued on consecutive cycles, each byte captured the following cycle.
REQ-020 Byte layout per classifier SHALL be: A1,B1,C1,D1,W1,A2,B2,C2,D2,W2,A3,B3,C3,D3,W3,threshold,left,right.
REQ-021 RECT SHALL last 13 cycles: 12 captured rect indices issued in layout order on o_ii_addr, values captured one cycle later.
REQ-022 Rect sum SHALL be A−B−C+D, signed II_WIDTH+2 bits; weights, threshold, left, right SHALL be signed 8-bit, sign-extended.
REQ-023 EVAL (1 cycle) SHALL form feature = W1·R1+W2·R2+W3·R3 at full precision (no overflow), select left if feature < threshold else right, add to accumulator.
REQ-024 Accumulator SHALL saturate at ±(2^(ACC_WIDTH−1)) limits, never wrap.
REQ-025 After EVAL: k+1 < count → PARAM for next classifier; else → THRESH.
REQ-026 THRESH (2 cycles) SHALL read byte base+18·count as signed stage threshold.
REQ-027 DONE (1 cycle) SHALL set o_iscandidate = (accumulator ≥ stage threshold), pulse o_done, then return to IDLE.
REQ-028 Latency from start sample edge to o_done high SHALL be 33·N+3 cycles (N=0 → 3).
REQ-029 i_start while busy SHALL be ignored; start in DONE cycle ignored (accepted from IDLE only).
REQ-030 Accumulator SHALL clear on start acceptance; captured count/base SHALL not change mid-stage.
REQ-031 o_rom_addr/o_ii_addr SHALL hold last value outside their issuing states.

Reset
REQ-032 On reset: state IDLE, o_busy=0, o_done=0, o_iscandidate=0, accumulator=0, o_rom_addr=0, o_ii_addr=0.
REQ-033 Reset mid-stage SHALL abort immediately with no o_done pulse; next start begins a clean stage.

Verification
REQ-034 N=1, rects give R1=40,R2=−10,R3=0, W=(−1,2,0), threshold=−50, left=−3, right=7, stage threshold=5 → feature −60, acc −3, o_iscandidate=0, o_done at cycle 36.
REQ-035 N=2, both classifiers select right=7, stage threshold=14 → acc 14, o_iscandidate=1 (equality passes), o_done at cycle 69.
REQ-036 N=0, stage threshold=0 → o_done at cycle 3, o_iscandidate=1; threshold=1 → 0.
REQ-037 ACC_WIDTH=8, N=20 each adding right=+10 → acc saturates at 127, no wrap; stage threshold 127 → candidate=1.
REQ-038 Assert reset at cycle 20 of an N=3 stage → o_busy 0 next cycle, no o_done; restart completes normally at 33·3+3.
REQ-039 Pulse i_start during PARAM with different base/count → ignored, result and latency unchanged; ROM/II address sequence matches layout order.
